// File: rtl/two_to_four_bit_decoder.sv
// rtl/two_to_four_bit_decoder.sv - 2-to-4 line decoder with enable, optional output register and polarity
module two_to_four_bit_decoder #(
   parameter bit OUT_ACTIVE_LOW = 1'b0,
   parameter bit REGISTERED     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic e,
   input  logic x0,
   input  logic x1,
   output logic y0,
   output logic y1,
   output logic y2,
   output logic y3
);

   logic [3:0] w_dec;
   logic [3:0] w_act;
   logic [3:0] w_out;

   // Decode is kept active-high internally; polarity is applied once at the output stage.
   always_comb begin
      w_dec = 4'b0000;
      if (e) begin
         w_dec = 4'b0001 << {x1, x0};
      end
   end

   generate
      if (REGISTERED) begin : g_reg
         logic [3:0] r_dec;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_dec <= 4'b0000;
            end else begin
               r_dec <= w_dec;
            end
         end

         assign w_act = r_dec;
      end else begin : g_comb
         // Clock and reset have no function in the combinational build.
         logic w_unused;
         assign w_unused = clk ^ rst_n;
         assign w_act    = w_dec;
      end
   endgenerate

   assign w_out = OUT_ACTIVE_LOW ? ~w_act : w_act;

   assign y0 = w_out[0];
   assign y1 = w_out[1];
   assign y2 = w_out[2];
   assign y3 = w_out[3];

endmodule

// File: tb/tb_two_to_four_bit_decoder.sv
// tb/tb_two_to_four_bit_decoder.sv - self-checking bench for two_to_four_bit_decoder
module tb_two_to_four_bit_decoder;

   logic clk = 1'b0;
   logic rst_n;
   logic e, x0, x1;
   logic d_y0, d_y1, d_y2, d_y3;
   logic a_y0, a_y1, a_y2, a_y3;
   logic c_y0, c_y1, c_y2, c_y3;

   int checks   = 0;
   int failures = 0;

   logic [3:0] exp_reg;

   always #5 clk = ~clk;

   two_to_four_bit_decoder #(.OUT_ACTIVE_LOW(1'b0), .REGISTERED(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .e(e), .x0(x0), .x1(x1),
      .y0(d_y0), .y1(d_y1), .y2(d_y2), .y3(d_y3)
   );

   two_to_four_bit_decoder #(.OUT_ACTIVE_LOW(1'b1), .REGISTERED(1'b1)) u_al (
      .clk(clk), .rst_n(rst_n), .e(e), .x0(x0), .x1(x1),
      .y0(a_y0), .y1(a_y1), .y2(a_y2), .y3(a_y3)
   );

   two_to_four_bit_decoder #(.OUT_ACTIVE_LOW(1'b0), .REGISTERED(1'b0)) u_comb (
      .clk(clk), .rst_n(rst_n), .e(e), .x0(x0), .x1(x1),
      .y0(c_y0), .y1(c_y1), .y2(c_y2), .y3(c_y3)
   );

   typedef struct {
      logic       e;
      logic       x1;
      logic       x0;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[10];

   // Reference: output n asserted exactly when enabled and the index equals n.
   function automatic logic [3:0] ref_dec(input logic en, input logic s1, input logic s0);
      logic [3:0] r;
      int idx;
      r   = 4'b0000;
      idx = s1 * 2 + s0;
      for (int n = 0; n < 4; n++) begin
         r[n] = en && (idx == n);
      end
      return r;
   endfunction

   function automatic logic [3:0] d_y();
      return {d_y3, d_y2, d_y1, d_y0};
   endfunction

   function automatic logic [3:0] a_y();
      return {a_y3, a_y2, a_y1, a_y0};
   endfunction

   function automatic logic [3:0] c_y();
      return {c_y3, c_y2, c_y1, c_y0};
   endfunction

   task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
      end
   endtask

   // Drive new inputs at the falling edge, verify hold and combinational path,
   // then verify the registered outputs after the next rising edge.
   task automatic step(input logic ne, input logic nx1, input logic nx0);
      @(negedge clk);
      drive_and_hold(ne, nx1, nx0);
      @(posedge clk);
      #1;
      exp_reg = ref_dec(ne, nx1, nx0);
      check("reg_out", d_y(), exp_reg);
      check("al_out", a_y(), ~exp_reg);
   endtask

   task automatic drive_and_hold(input logic ne, input logic nx1, input logic nx0);
      e  = ne;
      x1 = nx1;
      x0 = nx0;
      #1;
      check("hold", d_y(), exp_reg);
      check("comb_same_step", c_y(), ref_dec(ne, nx1, nx0));
   endtask

   initial begin
      vecs[0] = '{1'b1, 1'b0, 1'b0, 4'b0001};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 4'b0010};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 4'b0100};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 4'b1000};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 4'b0000};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 4'b0000};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 4'b0000};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 4'b0000};
      vecs[8] = '{1'b1, 1'b1, 1'b0, 4'b0100};
      vecs[9] = '{1'b0, 1'b1, 1'b0, 4'b0000};

      // Reset with an active decode on the inputs.
      rst_n = 1'b0;
      e  = 1'b1;
      x1 = 1'b1;
      x0 = 1'b1;
      exp_reg = 4'b0000;
      #1;
      check("reset_idle", d_y(), 4'b0000);
      check("reset_idle_al", a_y(), 4'b1111);
      check("reset_comb_unaffected", c_y(), 4'b1000);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", d_y(), 4'b0000);
      check("reset_held_al", a_y(), 4'b1111);

      // First edge after release captures the current inputs.
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("release_no_edge", d_y(), 4'b0000);
      @(posedge clk);
      #1;
      exp_reg = 4'b1000;
      check("startup", d_y(), 4'b1000);
      check("startup_al", a_y(), 4'b0111);
      #100;
      check("startup_stable", d_y(), 4'b1000);

      // Table sweep: one-hot sweep, disabled codes, e 1->0 with select 10.
      for (int i = 0; i < 10; i++) begin
         step(vecs[i].e, vecs[i].x1, vecs[i].x0);
         check($sformatf("vec%0d", i), d_y(), vecs[i].exp);
      end

      // Simultaneous change of enable and select.
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("simul_change", d_y(), 4'b1000);

      // Asynchronous reset between edges.
      step(1'b1, 1'b0, 1'b1);
      check("pre_reset_y1", d_y(), 4'b0010);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", d_y(), 4'b0000);
      check("async_reset_al", a_y(), 4'b1111);
      check("async_reset_comb", c_y(), 4'b0010);
      #1;
      rst_n = 1'b1;
      #1;
      exp_reg = 4'b0000;
      check("after_release_no_edge", d_y(), 4'b0000);
      @(posedge clk);
      #1;
      exp_reg = 4'b0010;
      check("after_release_edge", d_y(), 4'b0010);

      // Randomized stimulus against the reference model.
      for (int i = 0; i < 200; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         checks++;
         if ($countones(d_y()) > 1) begin
            failures++;
            $display("FAIL onehot got=%b exp=at_most_one_set", d_y());
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
